// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial converter with a one-word holding register for gapless streaming.
// Define SER_PARITY_EN to append one even-parity bit after the data bits of every frame.
module bit_stream_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x,
  output logic             x_valid,
  output logic             frame_done
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
`ifdef SER_PARITY_EN
    PARITY,
`endif
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic             accept;
  logic             frame_end;
  logic             load_now;
  logic [WIDTH-1:0] next_word;

  assign load_ready = ~hold_full_q;
  assign accept     = load_valid & load_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
`ifdef SER_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
`ifdef SER_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
`ifdef SER_PARITY_EN
    parity_d    = parity_q;
`endif
    x           = 1'b0;
    x_valid     = 1'b0;
    frame_end   = 1'b0;
    load_now    = 1'b0;
    next_word   = data_in;

    case (state_q)
      IDLE: begin
        load_now = accept;
      end
      SHIFT: begin
        x_valid = 1'b1;
        x       = (MSB_FIRST != 0) ? shift_q[WIDTH-1] : shift_q[0];
        shift_d = (MSB_FIRST != 0) ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
`ifdef SER_PARITY_EN
          state_d = PARITY;
          cnt_d   = '0;
`else
          frame_end = 1'b1;
`endif
        end
      end
`ifdef SER_PARITY_EN
      PARITY: begin
        x_valid   = 1'b1;
        x         = parity_q;
        frame_end = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase

    // Frame boundary: a held word takes priority (load_ready is low then), else a
    // word offered on this very edge goes straight into the shifter.
    if (frame_end) begin
      if (hold_full_q) begin
        load_now    = 1'b1;
        next_word   = hold_q;
        hold_d      = '0;
        hold_full_d = 1'b0;
      end else if (accept) begin
        load_now = 1'b1;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end else if (accept && state_q != IDLE) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end

    if (load_now) begin
      shift_d = next_word;
      cnt_d   = '0;
      state_d = SHIFT;
`ifdef SER_PARITY_EN
      parity_d = ^next_word;
`endif
    end
  end

  assign frame_done = frame_end;

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Directed bench for bit_stream_serializer with a bit-level expected-output queue.
module tb_bit_stream_serializer;

  localparam int W = 8;
`ifdef SER_PARITY_EN
  localparam int  FL  = W + 1;
  localparam bit  PAR = 1'b1;
`else
  localparam int  FL  = W;
  localparam bit  PAR = 1'b0;
`endif

  typedef struct packed {
    logic b;
    logic fd;
  } exp_bit_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data_in;
  logic         load_valid;
  logic         load_ready, x, x_valid, frame_done;

  logic [W-1:0] d2;
  logic         lv2;
  logic         lr2, x2, xv2, fd2;

  exp_bit_t     q[$];
  logic         rdy_m;
  int           n_vec = 0;
  int           n_err = 0;

  bit_stream_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
    .load_ready(load_ready), .x(x), .x_valid(x_valid), .frame_done(frame_done)
  );

  bit_stream_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .data_in(d2), .load_valid(lv2),
    .load_ready(lr2), .x(x2), .x_valid(xv2), .frame_done(fd2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [W-1:0] d, input bit msb);
    exp_bit_t e;
    for (int i = 0; i < W; i++) begin
      e.b  = msb ? d[W-1-i] : d[i];
      e.fd = (i == W - 1) && !PAR;
      q.push_back(e);
    end
    if (PAR) begin
      e.b  = ^d;
      e.fd = 1'b1;
      q.push_back(e);
    end
  endtask

  task automatic sample();
    if (q.size() > 0) begin
      check("x_valid", x_valid, 1'b1);
      check("x", x, q[0].b);
      check("frame_done", frame_done, q[0].fd);
    end else begin
      check("idle_x_valid", x_valid, 1'b0);
      check("idle_x", x, 1'b0);
      check("idle_frame_done", frame_done, 1'b0);
    end
    rdy_m = (q.size() <= FL);
    check("load_ready", load_ready, rdy_m);
    if (q.size() > 0) void'(q.pop_front());
  endtask

  // Drive one cycle of stimulus, then check the outputs that follow the edge.
  task automatic cyc(input logic v, input logic [W-1:0] d, output logic acc);
    load_valid = v;
    data_in    = d;
    acc        = v && rdy_m && rst;
    if (acc) push_word(d, 1'b1);
    @(negedge clk);
    sample();
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 200 && q.size() > 0; i++) cyc(1'b0, '0, acc);
    check("drain_bound", q.size() == 0, 1'b1);
    cyc(1'b0, '0, acc);
  endtask

  task automatic send_words(input logic [W-1:0] w0, input logic [W-1:0] w1,
                            input logic [W-1:0] w2);
    logic [W-1:0] ws[3];
    logic         acc;
    int unsigned  idx;
    int unsigned  tries;
    ws[0] = w0; ws[1] = w1; ws[2] = w2;
    idx   = 0;
    tries = 0;
    while (idx < 3 && tries < 100) begin
      cyc(1'b1, ws[idx], acc);
      if (acc) idx++;
      tries++;
    end
    check("send_bound", idx == 3, 1'b1);
  endtask

  initial begin
    logic         acc;
    logic [W-1:0] w;
    rst        = 1'b0;
    load_valid = 1'b0;
    data_in    = '0;
    lv2        = 1'b0;
    d2         = '0;
    rdy_m      = 1'b1;

    #2;
    check("rst_x", x, 1'b0);
    check("rst_x_valid", x_valid, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_load_ready", load_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Single word
    cyc(1'b1, 8'hA5, acc);
    drain();

    // Back-to-back streaming
    cyc(1'b1, 8'hA5, acc);
    cyc(1'b1, 8'h0F, acc);
    drain();

    // Backpressure with load_valid held high
    send_words(8'h11, 8'h22, 8'h33);
    drain();

    // Reset in the middle of a frame, data offered throughout reset
    cyc(1'b1, 8'hFF, acc);
    cyc(1'b0, '0, acc);
    cyc(1'b0, '0, acc);
    #2;
    rst        = 1'b0;
    load_valid = 1'b1;
    data_in    = 8'h05;
    #1;
    check("midrst_x", x, 1'b0);
    check("midrst_x_valid", x_valid, 1'b0);
    check("midrst_frame_done", frame_done, 1'b0);
    check("midrst_load_ready", load_ready, 1'b1);
    q.delete();
    repeat (2) begin
      @(negedge clk);
      sample();
    end
    rst = 1'b1;
    cyc(1'b1, 8'h05, acc);
    drain();

    // Parity-sensitive words (odd and even population)
    cyc(1'b1, 8'hA5, acc);
    drain();
    cyc(1'b1, 8'h07, acc);
    drain();

    // Random words streamed under backpressure
    for (int r = 0; r < 3; r++) begin
      w = W'($urandom);
      send_words(w, W'($urandom), W'($urandom));
      drain();
    end

    // LSB-first instance
    check("lsb_load_ready", lr2, 1'b1);
    check("lsb_idle_x_valid", xv2, 1'b0);
    lv2 = 1'b1;
    d2  = 8'h01;
    @(negedge clk);
    lv2 = 1'b0;
    for (int i = 0; i < FL; i++) begin
      check("lsb_x", x2, (i < W) ? d2[i] : ^d2);
      check("lsb_x_valid", xv2, 1'b1);
      check("lsb_frame_done", fd2, i == FL - 1);
      @(negedge clk);
    end
    check("lsb_end_x_valid", xv2, 1'b0);
    check("lsb_end_x", x2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
